cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_pkg.sv | 21 ++
 rtl/cdb_fifo.sv | 59 +++++
 rtl/cdb_arbiter.sv | 114 +++++++++++
 tb/tb_cdb_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_pkg.sv
// Shared types for the common data bus arbiter.
package cdb_pkg;

  localparam int XLEN = 32;
  localparam int CDB_TAG_W = 3;

  typedef enum logic {
    ARB_FIXED,
    ARB_RR
  } arb_mode_e;

  typedef struct packed {
    logic [CDB_TAG_W-1:0] tag;
    logic [XLEN-1:0]      value;
  } cdb_entry_t;

  function automatic int cdb_src_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdb_fifo.sv
// Per-channel result buffer; ready and not-empty come from registered state only.
module cdb_fifo
  import cdb_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = cdb_entry_t
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_squash,
  input  logic i_push,
  input  T     i_data,
  input  logic i_pop,
  output T     o_head,
  output logic o_ready,
  output logic o_nempty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  T              r_mem [DEPTH];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [CW-1:0] r_cnt;
  logic          w_push;
  logic          w_pop;

  assign w_push   = i_push && !i_squash;
  assign w_pop    = i_pop && (r_cnt != '0) && !i_squash;
  assign o_head   = r_mem[r_rd];
  assign o_ready  = (r_cnt < CW'(DEPTH));
  assign o_nempty = (r_cnt != '0);

  always_ff @(posedge i_clock) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else if (i_squash) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + PW'(1);
      if (w_pop)  r_rd <= r_rd + PW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Arbitrates buffered FU results onto a single registered result bus.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int        NUM_FU   = 5,
  parameter int        TAG_W    = 3,
  parameter int        DEPTH    = 2,
  parameter arb_mode_e ARB_MODE = ARB_RR
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               squash,
  input  logic [NUM_FU-1:0]                  fu_valid,
  input  logic [NUM_FU-1:0][TAG_W-1:0]       fu_tag,
  input  logic [NUM_FU-1:0][XLEN-1:0]        fu_value,
  output logic [NUM_FU-1:0]                  fu_ready,
  output logic                               cdb_valid,
  output logic [TAG_W-1:0]                   cdb_tag,
  output logic [XLEN-1:0]                    cdb_value,
  output logic [cdb_src_w(NUM_FU)-1:0]       cdb_src
);

  localparam int SRC_W = cdb_src_w(NUM_FU);

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  value;
  } entry_t;

  entry_t [NUM_FU-1:0] w_in;
  entry_t [NUM_FU-1:0] w_head;
  logic   [NUM_FU-1:0] w_nempty;
  logic   [NUM_FU-1:0] w_push;
  logic   [NUM_FU-1:0] w_pop;
  logic                w_gnt_any;
  logic   [SRC_W-1:0]  w_gnt_idx;
  logic   [SRC_W-1:0]  w_rr_nxt;
  int                  w_base;
  int                  w_i;

  logic                r_valid;
  logic   [TAG_W-1:0]  r_tag;
  logic   [XLEN-1:0]   r_value;
  logic   [SRC_W-1:0]  r_src;
  logic   [SRC_W-1:0]  r_rr;

  for (genvar g = 0; g < NUM_FU; g++) begin : g_ch
    assign w_in[g]   = {fu_tag[g], fu_value[g]};
    assign w_push[g] = fu_valid[g] & fu_ready[g];
    assign w_pop[g]  = w_gnt_any && (w_gnt_idx == SRC_W'(g));

    cdb_fifo #(
      .DEPTH (DEPTH),
      .T     (entry_t)
    ) u_fifo (
      .i_clock  (clock),
      .i_reset  (reset),
      .i_squash (squash),
      .i_push   (w_push[g]),
      .i_data   (w_in[g]),
      .i_pop    (w_pop[g]),
      .o_head   (w_head[g]),
      .o_ready  (fu_ready[g]),
      .o_nempty (w_nempty[g])
    );
  end

  // Fixed priority is a round-robin search that always starts at 0.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    w_base    = (ARB_MODE == ARB_RR) ? int'(r_rr) : 0;
    w_i       = 0;
    for (int k = 0; k < NUM_FU; k++) begin
      w_i = w_base + k;
      if (w_i >= NUM_FU) w_i = w_i - NUM_FU;
      if (!w_gnt_any && w_nempty[w_i]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = SRC_W'(w_i);
      end
    end
  end

  always_comb begin
    w_rr_nxt = w_gnt_idx + SRC_W'(1);
    if (w_gnt_idx == SRC_W'(NUM_FU - 1)) w_rr_nxt = '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_value <= '0;
      r_src   <= '0;
      r_rr    <= '0;
    end else if (squash) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_gnt_any;
      if (w_gnt_any) begin
        r_tag   <= w_head[w_gnt_idx].tag;
        r_value <= w_head[w_gnt_idx].value;
        r_src   <= w_gnt_idx;
        r_rr    <= w_rr_nxt;
      end
    end
  end

  assign cdb_valid = r_valid;
  assign cdb_tag   = r_tag;
  assign cdb_value = r_value;
  assign cdb_src   = r_src;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: one fixed-priority and one round-robin instance.
module tb_cdb_arbiter;
  import cdb_pkg::*;

  localparam int NF = 5;
  localparam int TW = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic squash = 1'b0;

  logic [NF-1:0]           fx_valid, rr_valid, fx_ready, rr_ready;
  logic [NF-1:0][TW-1:0]   fx_tag, rr_tag;
  logic [NF-1:0][XLEN-1:0] fx_value, rr_value;
  logic                    fx_cv, rr_cv;
  logic [TW-1:0]           fx_ct, rr_ct;
  logic [XLEN-1:0]         fx_cval, rr_cval;
  logic [2:0]              fx_src, rr_src;

  cdb_arbiter #(
    .NUM_FU(NF), .TAG_W(TW), .DEPTH(2), .ARB_MODE(ARB_FIXED)
  ) u_fx (
    .clock(clock), .reset(reset), .squash(squash),
    .fu_valid(fx_valid), .fu_tag(fx_tag), .fu_value(fx_value),
    .fu_ready(fx_ready), .cdb_valid(fx_cv), .cdb_tag(fx_ct),
    .cdb_value(fx_cval), .cdb_src(fx_src)
  );

  cdb_arbiter #(
    .NUM_FU(NF), .TAG_W(TW), .DEPTH(2), .ARB_MODE(ARB_RR)
  ) u_rr (
    .clock(clock), .reset(reset), .squash(squash),
    .fu_valid(rr_valid), .fu_tag(rr_tag), .fu_value(rr_value),
    .fu_ready(rr_ready), .cdb_valid(rr_cv), .cdb_tag(rr_ct),
    .cdb_value(rr_cval), .cdb_src(rr_src)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    int src;
    int tag;
    int val;
    int cyc;
  } exp_t;

  exp_t q_fx[$];
  exp_t q_rr[$];

  int left[NF];
  int sent[NF];
  int base[NF];
  int tg[NF];

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic expect_e(input bit fx, input int s, input int t,
                          input int v, input int c);
    exp_t e;
    e.src = s; e.tag = t; e.val = v; e.cyc = c;
    if (fx) q_fx.push_back(e);
    else    q_rr.push_back(e);
  endtask

  task automatic sb_check(input string nm, input bit fx, input int s,
                          input int t, input int v);
    exp_t e;
    n_chk++;
    if ((fx && q_fx.size() == 0) || (!fx && q_rr.size() == 0)) begin
      n_fail++;
      $display("FAIL %s_unexpected: got src=%0d tag=%0d val=0x%0h cyc=%0d, expected no broadcast",
               nm, s, t, v, cyc);
      return;
    end
    if (fx) e = q_fx.pop_front();
    else    e = q_rr.pop_front();
    if (s != e.src || t != e.tag || v != e.val ||
        (e.cyc >= 0 && cyc != e.cyc)) begin
      n_fail++;
      $display("FAIL %s_bcast: got src=%0d tag=%0d val=0x%0h cyc=%0d, expected src=%0d tag=%0d val=0x%0h cyc=%0d",
               nm, s, t, v, cyc, e.src, e.tag, e.val, e.cyc);
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (fx_cv) sb_check("fx", 1'b1, int'(fx_src), int'(fx_ct), int'(fx_cval));
      if (rr_cv) sb_check("rr", 1'b0, int'(rr_src), int'(rr_ct), int'(rr_cval));
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic clr();
    for (int i = 0; i < NF; i++) begin
      left[i] = 0; sent[i] = 0; base[i] = 0; tg[i] = 0;
    end
  endtask

  // Offers left[i] values per channel, each held until accepted.
  task automatic drive(input bit fx, input int chk_ch, input int maxc);
    logic [NF-1:0] v, rdy, acc;
    bit chk_done;
    chk_done = 1'b0;
    for (int k = 0; k < maxc; k++) begin
      for (int i = 0; i < NF; i++) begin
        v[i] = (left[i] > 0);
        if (fx) begin
          fx_tag[i]   = TW'(tg[i]);
          fx_value[i] = XLEN'(base[i] + sent[i]);
        end else begin
          rr_tag[i]   = TW'(tg[i]);
          rr_value[i] = XLEN'(base[i] + sent[i]);
        end
      end
      if (fx) fx_valid = v;
      else    rr_valid = v;
      if (v == '0) return;
      @(negedge clock);
      rdy = fx ? fx_ready : rr_ready;
      acc = v & rdy;
      if (chk_ch >= 0 && !chk_done && sent[chk_ch] == 2) begin
        chk_done = 1'b1;
        check("ready_full", int'(rdy[chk_ch]), 0);
      end
      @(posedge clock);
      #1;
      for (int i = 0; i < NF; i++) begin
        if (acc[i]) begin
          sent[i]++;
          left[i]--;
        end
      end
    end
    n_chk++;
    n_fail++;
    $display("FAIL drive_timeout: got %0d cycles without completion, required completion", maxc);
    fx_valid = '0;
    rr_valid = '0;
  endtask

  int c;

  initial begin
    fx_valid = '0; rr_valid = '0;
    fx_tag = '0; rr_tag = '0;
    fx_value = '0; rr_value = '0;
    clr();

    idle(3);
    check("rst_fx_valid", int'(fx_cv), 0);
    check("rst_fx_tag", int'(fx_ct), 0);
    check("rst_fx_value", int'(fx_cval), 0);
    check("rst_fx_src", int'(fx_src), 0);
    check("rst_rr_valid", int'(rr_cv), 0);
    reset = 1'b0;
    idle(1);
    check("rel_fx_ready", int'(fx_ready), 31);
    check("rel_rr_ready", int'(rr_ready), 31);

    // Single result on channel 3: bus shows it two edges after the offer starts.
    clr();
    left[3] = 1; tg[3] = 5; base[3] = 'h2A;
    c = cyc;
    expect_e(1'b0, 3, 5, 'h2A, c + 2);
    drive(1'b0, -1, 20);
    idle(6);

    // Fixed priority, three simultaneous pushes.
    clr();
    left[0] = 1; tg[0] = 1; base[0] = 'h10;
    left[1] = 1; tg[1] = 2; base[1] = 'h20;
    left[3] = 1; tg[3] = 3; base[3] = 'h30;
    c = cyc;
    expect_e(1'b1, 0, 1, 'h10, c + 2);
    expect_e(1'b1, 1, 2, 'h20, c + 3);
    expect_e(1'b1, 3, 3, 'h30, c + 4);
    drive(1'b1, -1, 20);
    idle(6);

    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(1);

    // Round-robin with every channel busy.
    clr();
    for (int i = 0; i < NF; i++) begin
      left[i] = 3; tg[i] = i; base[i] = i * 16;
    end
    c = cyc;
    for (int m = 0; m < 15; m++)
      expect_e(1'b0, m % 5, m % 5, (m % 5) * 16 + m / 5, c + 2 + m);
    drive(1'b0, -1, 40);
    idle(10);

    // Channel 2 backs up behind a saturated channel 0.
    clr();
    left[0] = 6; tg[0] = 6; base[0] = 'h60;
    left[2] = 3; tg[2] = 2; base[2] = 'h20;
    c = cyc;
    for (int j = 0; j < 6; j++) expect_e(1'b1, 0, 6, 'h60 + j, c + 2 + j);
    expect_e(1'b1, 2, 2, 'h20, c + 8);
    expect_e(1'b1, 2, 2, 'h21, c + 9);
    expect_e(1'b1, 2, 2, 'h22, c + 10);
    drive(1'b1, 2, 30);
    idle(6);

    // Squash with a concurrent push on channel 0.
    c = cyc;
    expect_e(1'b0, 1, 1, 'h11, c + 2);
    rr_valid = 5'b10010;
    rr_tag[1] = 3'd1; rr_tag[4] = 3'd4;
    rr_value[1] = 'h11; rr_value[4] = 'h41;
    idle(1);
    rr_value[1] = 'h12; rr_value[4] = 'h42;
    idle(1);
    rr_valid = 5'b00001;
    rr_tag[0] = 3'd7; rr_value[0] = 'h77;
    squash = 1'b1;
    idle(1);
    rr_valid = '0;
    squash = 1'b0;
    @(negedge clock);
    check("squash_valid", int'(rr_cv), 0);
    check("squash_ready", int'(rr_ready), 31);
    idle(1);
    // Pointer sits at 2 after the squash, so channel 3 beats channel 0.
    clr();
    left[0] = 1; tg[0] = 2; base[0] = 'h02;
    left[3] = 1; tg[3] = 3; base[3] = 'h03;
    c = cyc;
    expect_e(1'b0, 3, 3, 'h03, c + 2);
    expect_e(1'b0, 0, 2, 'h02, c + 3);
    drive(1'b0, -1, 20);
    idle(6);

    // Asynchronous reset in the middle of a stream.
    c = cyc;
    expect_e(1'b1, 1, 1, 'h55, c + 2);
    fx_valid = 5'b00010;
    fx_tag[1] = 3'd1; fx_value[1] = 'h55;
    idle(1);
    fx_value[1] = 'h56;
    idle(1);
    fx_valid = '0;
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("arst_valid", int'(fx_cv), 0);
    check("arst_value", int'(fx_cval), 0);
    check("arst_src", int'(fx_src), 0);
    @(negedge clock);
    reset = 1'b0;
    idle(1);
    check("arst_rel_ready", int'(fx_ready), 31);
    check("arst_rel_valid", int'(fx_cv), 0);
    clr();
    left[2] = 1; tg[2] = 4; base[2] = 'h99;
    c = cyc;
    expect_e(1'b1, 2, 4, 'h99, c + 2);
    drive(1'b1, -1, 20);
    idle(6);

    check("fx_leftover", q_fx.size(), 0);
    check("rr_leftover", q_rr.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
